// File: rtl/zxuno_regbus.sv
// Z80-side front end of the ZX-UNO register bus: decodes the address/data
// ports, holds the selected register number and emits per-access strobes.
module zxuno_regbus #(
  parameter logic [15:0] ADDR_PORT  = 16'hFC3B,
  parameter logic [15:0] DATA_PORT  = 16'hFD3B,
  parameter logic [7:0]  RESET_ADDR = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        m1_n,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  dout,
  output logic        oe_n,
  output logic [7:0]  zxuno_addr,
  output logic        zxuno_regrd,
  output logic        zxuno_regwr,
  output logic [7:0]  zxuno_wrdata,
  output logic        regaddr_changed,
  input  logic [7:0]  reg_din,
  input  logic        reg_oe_n
);

  typedef enum logic [1:0] {ST_WAIT, ST_IDLE, ST_ACT} state_t;

  logic [15:0] a_q;
  logic        iorq_n_q, rd_n_q, wr_n_q, m1_n_q;
  logic [7:0]  cpu_dout_q;

  state_t      state_q, state_d;
  logic        is_addr_q, is_addr_d;
  logic        is_rd_q, is_rd_d;
  logic [7:0]  addr_q, addr_d;
  logic [7:0]  wrdata_q, wrdata_d;
  logic        regwr_q, regwr_d;
  logic        chg_q, chg_d;

  logic        rd_act, wr_act, hit_addr, hit_data;

  // Input stage is deliberately not reset: after reset the FSM must still see
  // a strobe that is being held, so it can wait for it to go away.
  always_ff @(posedge clk) begin
    a_q        <= a;
    iorq_n_q   <= iorq_n;
    rd_n_q     <= rd_n;
    wr_n_q     <= wr_n;
    m1_n_q     <= m1_n;
    cpu_dout_q <= cpu_dout;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_WAIT;
      is_addr_q <= 1'b0;
      is_rd_q   <= 1'b0;
      addr_q    <= RESET_ADDR;
      wrdata_q  <= 8'h00;
      regwr_q   <= 1'b0;
      chg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_addr_q <= is_addr_d;
      is_rd_q   <= is_rd_d;
      addr_q    <= addr_d;
      wrdata_q  <= wrdata_d;
      regwr_q   <= regwr_d;
      chg_q     <= chg_d;
    end
  end

  always_comb begin
    rd_act    = !iorq_n_q && !rd_n_q && m1_n_q;
    wr_act    = !iorq_n_q && !wr_n_q && m1_n_q;
    hit_addr  = (a_q == ADDR_PORT);
    hit_data  = (a_q == DATA_PORT);
    state_d   = state_q;
    is_addr_d = is_addr_q;
    is_rd_d   = is_rd_q;
    addr_d    = addr_q;
    wrdata_d  = wrdata_q;
    regwr_d   = 1'b0;
    chg_d     = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (!rd_act && !wr_act) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if ((rd_act || wr_act) && (hit_addr || hit_data)) begin
          state_d   = ST_ACT;
          is_addr_d = hit_addr;
          is_rd_d   = rd_act;
          if (!rd_act) begin
            if (hit_addr) begin
              addr_d = cpu_dout_q;
              chg_d  = 1'b1;
            end else begin
              wrdata_d = cpu_dout_q;
              regwr_d  = 1'b1;
            end
          end
        end
      end
      ST_ACT: begin
        // Leave only when the strobe that opened the access drops.
        if (is_rd_q ? !rd_act : !wr_act) state_d = ST_IDLE;
      end
      default: state_d = ST_WAIT;
    endcase
  end

  always_comb begin
    zxuno_regrd = (state_q == ST_ACT) && is_rd_q && !is_addr_q;
    oe_n        = 1'b1;
    dout        = 8'hFF;
    if ((state_q == ST_ACT) && is_rd_q) begin
      if (is_addr_q) begin
        oe_n = 1'b0;
        dout = addr_q;
      end else if (!reg_oe_n) begin
        oe_n = 1'b0;
        dout = reg_din;
      end
    end
  end

  assign zxuno_addr      = addr_q;
  assign zxuno_wrdata    = wrdata_q;
  assign zxuno_regwr     = regwr_q;
  assign regaddr_changed = chg_q;

endmodule

// File: tb/tb_zxuno_regbus.sv
// Directed + randomized bench for zxuno_regbus; expected outputs come from a
// per-access timing model (strobes two samples after pin assert, held for the access).
module tb_zxuno_regbus;

  localparam logic [15:0] ADDR_PORT = 16'hFC3B;
  localparam logic [15:0] DATA_PORT = 16'hFD3B;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] a;
  logic        iorq_n, rd_n, wr_n, m1_n;
  logic [7:0]  cpu_dout;
  logic [7:0]  dout;
  logic        oe_n;
  logic [7:0]  zxuno_addr;
  logic        zxuno_regrd, zxuno_regwr;
  logic [7:0]  zxuno_wrdata;
  logic        regaddr_changed;
  logic [7:0]  reg_din;
  logic        reg_oe_n;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] m_addr;
  logic [7:0] m_wrdata;

  zxuno_regbus dut (
    .clk(clk), .rst_n(rst_n), .a(a), .iorq_n(iorq_n), .rd_n(rd_n),
    .wr_n(wr_n), .m1_n(m1_n), .cpu_dout(cpu_dout), .dout(dout), .oe_n(oe_n),
    .zxuno_addr(zxuno_addr), .zxuno_regrd(zxuno_regrd),
    .zxuno_regwr(zxuno_regwr), .zxuno_wrdata(zxuno_wrdata),
    .regaddr_changed(regaddr_changed), .reg_din(reg_din), .reg_oe_n(reg_oe_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic exp_rd, input logic exp_wr,
                         input logic exp_chg, input logic exp_oe, input logic [7:0] exp_dout);
    chk({tag, ".addr"},   zxuno_addr, m_addr);
    chk({tag, ".wrdata"}, zxuno_wrdata, m_wrdata);
    chk({tag, ".regrd"},  {7'd0, zxuno_regrd}, {7'd0, exp_rd});
    chk({tag, ".regwr"},  {7'd0, zxuno_regwr}, {7'd0, exp_wr});
    chk({tag, ".chg"},    {7'd0, regaddr_changed}, {7'd0, exp_chg});
    chk({tag, ".oe_n"},   {7'd0, oe_n}, {7'd0, exp_oe});
    chk({tag, ".dout"},   dout, exp_dout);
  endtask

  task automatic idle_pins();
    iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; m1_n = 1'b1;
  endtask

  // One CPU I/O cycle with pins held for 'hold' clocks; called at a negedge
  // with pins idle, returns at a negedge with the bus back to idle.
  task automatic access(input string tag, input logic [15:0] adr, input logic [7:0] data,
                        input bit wr, input bit intack, input int hold,
                        input logic [7:0] rdin, input bit roe_n);
    bit hit_a, hit_d, act;
    logic exp_rd, exp_oe;
    logic [7:0] exp_dout;
    hit_a = (adr == ADDR_PORT) && !intack;
    hit_d = (adr == DATA_PORT) && !intack;
    a = adr; cpu_dout = data; reg_din = rdin; reg_oe_n = roe_n;
    iorq_n = 1'b0; m1_n = !intack; rd_n = wr; wr_n = !wr;
    for (int i = 1; i <= hold + 2; i++) begin
      @(negedge clk);
      act = (i >= 2) && (i <= hold + 1);
      if (i == 2 && wr && hit_a) m_addr = data;
      if (i == 2 && wr && hit_d) m_wrdata = data;
      exp_rd   = act && !wr && hit_d;
      exp_oe   = 1'b1;
      exp_dout = 8'hFF;
      if (act && !wr && hit_a) begin exp_oe = 1'b0; exp_dout = m_addr; end
      if (exp_rd && !roe_n) begin exp_oe = 1'b0; exp_dout = rdin; end
      chk_all(tag, exp_rd, (i == 2) && wr && hit_d, (i == 2) && wr && hit_a, exp_oe, exp_dout);
      if (i == hold) idle_pins();
    end
  endtask

  initial begin
    logic [15:0] radr;
    logic [7:0]  rdat, rdin;
    int          sel;
    rst_n = 1'b0; a = 16'h0000; cpu_dout = 8'h00; reg_din = 8'h00; reg_oe_n = 1'b1;
    idle_pins();
    m_addr = 8'h00; m_wrdata = 8'h00;
    repeat (3) @(negedge clk);
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_all("post_reset", 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);

    access("addr_wr_ff",   ADDR_PORT, 8'hFF, 1'b1, 1'b0, 4, 8'h00, 1'b1);
    access("addr_wr_ff2",  ADDR_PORT, 8'hFF, 1'b1, 1'b0, 2, 8'h00, 1'b1);
    access("addr_wr_42",   ADDR_PORT, 8'h42, 1'b1, 1'b0, 1, 8'h00, 1'b1);
    access("addr_rd",      ADDR_PORT, 8'h00, 1'b0, 1'b0, 2, 8'h11, 1'b0);
    access("data_rd_54",   DATA_PORT, 8'h00, 1'b0, 1'b0, 3, 8'h54, 1'b0);
    access("data_rd_none", DATA_PORT, 8'h00, 1'b0, 1'b0, 3, 8'h54, 1'b1);
    access("data_wr_a5",   DATA_PORT, 8'hA5, 1'b1, 1'b0, 2, 8'h00, 1'b1);
    access("foreign_fe",   16'h00FE,  8'h33, 1'b1, 1'b0, 2, 8'h00, 1'b1);
    access("foreign_fd3a", 16'hFD3A,  8'h77, 1'b1, 1'b0, 2, 8'h00, 1'b1);
    access("intack",       DATA_PORT, 8'h99, 1'b1, 1'b1, 2, 8'h00, 1'b1);

    for (int n = 0; n < 40; n++) begin
      sel  = $urandom_range(0, 5);
      rdat = 8'($urandom_range(0, 255));
      rdin = 8'($urandom_range(0, 255));
      radr = 16'($urandom_range(0, 65535));
      if (radr == ADDR_PORT || radr == DATA_PORT) radr = radr ^ 16'h0100;
      if (sel == 0 || sel == 1) radr = ADDR_PORT;
      if (sel == 2 || sel == 3) radr = DATA_PORT;
      if (sel == 4 && rdat[0]) radr = DATA_PORT ^ 16'h0001;
      access("rand", radr, rdat, bit'($urandom_range(0, 1)), (sel == 5) && rdat[1],
             $urandom_range(1, 4), rdin, bit'($urandom_range(0, 1)));
    end

    // Reset while a data-port read is in progress, release with strobe held.
    a = DATA_PORT; reg_din = 8'h3C; reg_oe_n = 1'b0;
    iorq_n = 1'b0; rd_n = 1'b0; wr_n = 1'b1; m1_n = 1'b1;
    repeat (2) @(negedge clk);
    chk_all("rst_mid_pre", 1'b1, 1'b0, 1'b0, 1'b0, 8'h3C);
    rst_n = 1'b0;
    @(negedge clk);
    m_addr = 8'h00; m_wrdata = 8'h00;
    chk_all("rst_mid_in", 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_all("rst_mid_held", 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);
    end
    idle_pins();
    repeat (2) begin
      @(negedge clk);
      chk_all("rst_mid_rel", 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF);
    end
    access("rst_new_rd", DATA_PORT, 8'h00, 1'b0, 1'b0, 2, 8'h5A, 1'b0);
    access("rst_new_wr", ADDR_PORT, 8'hC3, 1'b1, 1'b0, 1, 8'h00, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/zxuno_regbus.md
# zxuno_regbus

Z80-side front end of the ZX-UNO extended register bus. Decodes I/O accesses to the address port (0xFC3B) and the data port (0xFD3B). Holds the currently selected register number and emits the read-level, write-pulse and address-change strobes consumed by all register-mapped peripherals, such as the core-ID string reader. It also merges the peripherals' read data back onto the CPU data-in path.

## Interface
Parameters:
- ADDR_PORT, 16'hFC3B, full 16-bit I/O address of the register-select port
- DATA_PORT, 16'hFD3B, full 16-bit I/O address of the register-data port
- RESET_ADDR, 8'h00, value of zxuno_addr after reset

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- a  in  16  Z80 address bus
- iorq_n, rd_n, wr_n, m1_n  in  1 each  Z80 control strobes, already in the clk domain
- cpu_dout  in  8  Z80 data out (write data)
- dout  out  8  read data toward the CPU data-in mux
- oe_n  out  1  low when dout must drive the CPU data-in mux
- zxuno_addr  out  8  selected register number
- zxuno_regrd  out  1  level: a data-port read is in progress
- zxuno_regwr  out  1  one-cycle pulse: a data-port write started
- zxuno_wrdata  out  8  data captured for the data-port write
- regaddr_changed  out  1  one-cycle pulse: the address port was written
- reg_din  in  8  OR-merged read data from peripherals
- reg_oe_n  in  1  AND-merged oe_n from peripherals (low = a peripheral is driving)

## Operation
- Input stage: a, iorq_n, rd_n, wr_n, m1_n and cpu_dout are registered once every clk. All decoding uses the registered copies.
- Derived signals: rd_act = !iorq_n & !rd_n & m1_n; wr_act = !iorq_n & !wr_n & m1_n. Interrupt acknowledge (m1_n low) is never decoded.
- Port decode: a full 16-bit compare against ADDR_PORT and DATA_PORT. Any other address is ignored.
- FSM states: WAIT, IDLE, ACT.
  - WAIT is the reset state. It moves to IDLE on the first cycle where neither rd_act nor wr_act is set. An access already in progress when reset is released produces no strobes.
  - IDLE moves to ACT when rd_act or wr_act is set and the address matches a port. On that cycle the port identity and direction are latched.
  - ACT moves to IDLE when the strobe that started the access is no longer active.
  - Each access produces exactly one set of strobes, however long the strobe is held.
- Address-port write, on the IDLE->ACT transition:
  - zxuno_addr <= cpu_dout.
  - regaddr_changed pulses high for 1 cycle, even if the written value equals the current zxuno_addr.
- Address-port read, while in ACT: oe_n = 0 and dout = zxuno_addr.
- Data-port write, on the IDLE->ACT transition:
  - zxuno_wrdata <= cpu_dout.
  - zxuno_regwr pulses high for 1 cycle.
  - zxuno_wrdata holds its value until the next data-port write.
- Data-port read:
  - zxuno_regrd = 1 for every cycle spent in ACT on a read access.
  - oe_n = reg_oe_n and dout = reg_din.
  - If no peripheral claims the register (reg_oe_n = 1), then oe_n = 1 and dout = 8'hFF.
- When idle or decoding a foreign port: oe_n = 1, dout = 8'hFF, zxuno_regrd = 0.
- Reset values: zxuno_addr = RESET_ADDR, zxuno_wrdata = 8'h00, zxuno_regrd = 0, zxuno_regwr = 0, regaddr_changed = 0, oe_n = 1, dout = 8'hFF, FSM = WAIT.

## Timing
- Latency: a strobe edge on the pins reaches the input register at clk edge N. The FSM enters ACT at edge N+1.
  - zxuno_addr, zxuno_wrdata, regaddr_changed and zxuno_regwr all become visible together after edge N+1, so they are valid in the same cycle.
- Release: zxuno_regrd and oe_n are driven from FSM state. They deassert in the cycle after the registered strobe goes inactive, which is edge N+1 after the pin release.
  - Peripherals therefore see the falling edge of zxuno_regrd exactly once per read.
- Back-to-back accesses: at least one registered cycle with the strobe inactive is required between accesses. Without it, a held strobe counts as a single access.
- Reset has priority over everything. If rst_n is asserted mid-ACT, zxuno_regrd and oe_n drop on the next edge.

## Test plan
- Write 8'hFF to 0xFC3B with the strobe held 4 cycles -> zxuno_addr = 8'hFF, and regaddr_changed is high for exactly 1 cycle, in the same cycle the new address appears.
- Write 8'hFF to 0xFC3B twice -> two separate 1-cycle regaddr_changed pulses; zxuno_addr stays 8'hFF.
- Read 0xFC3B after a write of 8'h42 -> oe_n = 0 and dout = 8'h42 while the strobe is held; oe_n = 1 one cycle after release.
- Read 0xFD3B with reg_din = 8'h54 and reg_oe_n = 0, strobe held 3 cycles -> zxuno_regrd high for 3 cycles, dout = 8'h54; a repeat with reg_oe_n = 1 gives oe_n = 1 and dout = 8'hFF.
- Write 8'hA5 to 0xFD3B, then to 0x00FE and 0xFD3A -> one zxuno_regwr pulse and zxuno_wrdata = 8'hA5; no strobes for the other two addresses.
- Hold a data-port read, pulse rst_n low, release rst_n while the strobe is still active -> zxuno_regrd = 0 and zxuno_addr = 8'h00; no zxuno_regrd until the strobe is released and a new read starts.
